// File: rtl/tcm_transmitter_framer.sv
// -----------------------------------------------------------------------------
// tcm_transmitter_framer
//
// Purpose:
//   Transmit-side framer for the 10-bit TCM sync-code link. Payload words
//   arrive on a valid/ready stream. The framer wraps every line in a 6-word
//   sync header and a 6-word sync trailer. The link receiver decodes these as
//   SOF/SOL and EOL/EOF. An idle gap separates consecutive lines. Exactly one
//   link word is emitted per clock.
//
// Parameters:
//   LINE_WORDS - payload words per line (>=1)
//   LINES      - lines per frame (>=1)
//   GAP        - idle words between a line trailer and the next header (>=0)
//   IDLE_WORD  - fill word for idle, gaps and underrun (not 3FF or 000)
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   start      in   frame request, only sampled while idle
//   s_data     in   [9:0] payload word
//   s_valid    in   payload word valid
//   s_ready    out  payload consumed this cycle (combinational, high in PAYLOAD)
//   tdat       out  [9:0] registered link word
//   busy       out  registered, high whenever the framer is not idle
//   frame_done out  one-cycle pulse, the cycle after the final EOF word
//   underrun   out  one-cycle pulse per payload slot filled with IDLE_WORD
// -----------------------------------------------------------------------------
module tcm_transmitter_framer #(
  parameter int         LINE_WORDS = 16,
  parameter int         LINES      = 4,
  parameter int         GAP        = 4,
  parameter logic [9:0] IDLE_WORD  = 10'h200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [9:0] tdat,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  // One word counter serves header, payload, trailer and gap. It must hold
  // the largest of those lengths.
  localparam int WMAX_A = (LINE_WORDS > 6) ? LINE_WORDS : 6;
  localparam int WMAX   = (GAP > WMAX_A) ? GAP : WMAX_A;
  localparam int WCW    = (WMAX > 1) ? $clog2(WMAX) : 1;
  localparam int LCW    = (LINES > 1) ? $clog2(LINES) : 1;

  localparam logic [WCW-1:0] LAST_SYNC = WCW'(5);
  localparam logic [WCW-1:0] LAST_PAY  = WCW'(LINE_WORDS - 1);
  localparam logic [WCW-1:0] LAST_GAP  = WCW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [LCW-1:0] LAST_LINE = LCW'(LINES - 1);
  localparam logic           HAS_GAP   = (GAP > 0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_TRL     = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [WCW-1:0] r_word_cnt;
  logic [WCW-1:0] w_word_cnt_nxt;
  logic [LCW-1:0] r_line_cnt;
  logic [LCW-1:0] w_line_cnt_nxt;
  logic [9:0]     w_tdat;
  logic           w_underrun;
  logic           w_eof;
  logic           r_eof_d;

  // Header and trailer share one shape: 3FF,000,3FF,3FF,S0,S1. Each S word is
  // either all-ones or all-zeros, and the flag selects which.
  function automatic logic [9:0] sync_word(input logic [WCW-1:0] idx,
                                           input logic s0_ones,
                                           input logic s1_ones);
    logic [9:0] w;
    case (idx)
      WCW'(0):  w = 10'h3FF;
      WCW'(1):  w = 10'h000;
      WCW'(2):  w = 10'h3FF;
      WCW'(3):  w = 10'h3FF;
      WCW'(4):  w = s0_ones ? 10'h3FF : 10'h000;
      WCW'(5):  w = s1_ones ? 10'h3FF : 10'h000;
      default:  w = IDLE_WORD;
    endcase
    return w;
  endfunction

  // Payload must never carry the all-ones or all-zeros codes. Otherwise the
  // receiver could lock onto a false sync.
  function automatic logic [9:0] clip(input logic [9:0] d);
    logic [9:0] w;
    if (d == 10'h3FF) begin
      w = 10'h3FE;
    end else if (d == 10'h000) begin
      w = 10'h001;
    end else begin
      w = d;
    end
    return w;
  endfunction

  assign s_ready = (r_state == ST_PAYLOAD);

  // Next-state, counter and next-word selection
  always_comb begin
    w_next_state   = r_state;
    w_word_cnt_nxt = r_word_cnt;
    w_line_cnt_nxt = r_line_cnt;
    w_tdat         = IDLE_WORD;
    w_underrun     = 1'b0;
    w_eof          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_word_cnt_nxt = {WCW{1'b0}};
        w_line_cnt_nxt = {LCW{1'b0}};
        if (start) begin
          w_next_state = ST_HDR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HDR: begin
        // SOF on line 0 (S0=000), SOL otherwise (S0=3FF); S1 is 3FF for both.
        w_tdat = sync_word(r_word_cnt, (r_line_cnt != {LCW{1'b0}}), 1'b1);
        if (r_word_cnt == LAST_SYNC) begin
          w_next_state   = ST_PAYLOAD;
          w_word_cnt_nxt = {WCW{1'b0}};
        end else begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
        end
      end
      ST_PAYLOAD: begin
        // A missing word is replaced by IDLE_WORD. The slot still counts, so
        // the line length is fixed.
        if (s_valid) begin
          w_tdat = clip(s_data);
        end else begin
          w_tdat     = IDLE_WORD;
          w_underrun = 1'b1;
        end
        if (r_word_cnt == LAST_PAY) begin
          w_next_state   = ST_TRL;
          w_word_cnt_nxt = {WCW{1'b0}};
        end else begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
        end
      end
      ST_TRL: begin
        // EOL (S0=3FF) on intermediate lines, EOF (S0=000) on the last; S1=000.
        w_tdat = sync_word(r_word_cnt, (r_line_cnt != LAST_LINE), 1'b0);
        if (r_word_cnt == LAST_SYNC) begin
          w_word_cnt_nxt = {WCW{1'b0}};
          if (r_line_cnt == LAST_LINE) begin
            w_next_state = ST_IDLE;
            w_eof        = 1'b1;
          end else begin
            w_line_cnt_nxt = r_line_cnt + LCW'(1);
            w_next_state   = HAS_GAP ? ST_GAP : ST_HDR;
          end
        end else begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
        end
      end
      ST_GAP: begin
        w_tdat = IDLE_WORD;
        if (r_word_cnt == LAST_GAP) begin
          w_next_state   = ST_HDR;
          w_word_cnt_nxt = {WCW{1'b0}};
        end else begin
          w_word_cnt_nxt = r_word_cnt + WCW'(1);
        end
      end
      default: begin
        w_next_state   = ST_IDLE;
        w_word_cnt_nxt = {WCW{1'b0}};
        w_line_cnt_nxt = {LCW{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= {WCW{1'b0}};
      r_line_cnt <= {LCW{1'b0}};
      tdat       <= IDLE_WORD;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      r_eof_d    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_word_cnt <= w_word_cnt_nxt;
      r_line_cnt <= w_line_cnt_nxt;
      tdat       <= w_tdat;
      busy       <= (w_next_state != ST_IDLE);
      underrun   <= w_underrun;
      // The final EOF word shows on tdat one cycle after it is chosen.
      // frame_done is delayed one more cycle so it follows that word.
      r_eof_d    <= w_eof;
      frame_done <= r_eof_d;
    end
  end

endmodule

// File: tb/tb_tcm_transmitter_framer.sv
// -----------------------------------------------------------------------------
// tb_tcm_transmitter_framer
//
// Directed bench for tcm_transmitter_framer. The main instance uses LINES=2,
// LINE_WORDS=4 and GAP=2. A second instance uses GAP=0 and checks back-to-back
// lines. Expected link streams are hand-written tables.
// -----------------------------------------------------------------------------
module tb_tcm_transmitter_framer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [9:0] tdat;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  logic       start0;
  logic [9:0] s_data0;
  logic       s_valid0;
  logic       s_ready0;
  logic [9:0] tdat0;
  logic       busy0;
  logic       frame_done0;
  logic       underrun0;

  int n_vec;
  int n_fail;
  int p;
  int busy_cnt;
  int und_cnt;
  int fd_cnt;

  logic [9:0] pay_d [8];
  logic       pay_v [8];

  logic [9:0] exp1 [34] = '{
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF,
    10'h00A, 10'h00B, 10'h00C, 10'h00D,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000,
    10'h200, 10'h200,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
    10'h00E, 10'h00F, 10'h010, 10'h011,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h000};

  logic [9:0] exp2 [34] = '{
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF,
    10'h3FE, 10'h001, 10'h155, 10'h123,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000,
    10'h200, 10'h200,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
    10'h050, 10'h051, 10'h200, 10'h053,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h000};

  logic [9:0] exp0 [32] = '{
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h3FF,
    10'h100, 10'h100, 10'h100, 10'h100,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
    10'h100, 10'h100, 10'h100, 10'h100,
    10'h3FF, 10'h000, 10'h3FF, 10'h3FF, 10'h000, 10'h000};

  tcm_transmitter_framer #(
    .LINE_WORDS(4), .LINES(2), .GAP(2), .IDLE_WORD(10'h200)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .tdat(tdat), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  tcm_transmitter_framer #(
    .LINE_WORDS(4), .LINES(2), .GAP(0), .IDLE_WORD(10'h200)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start0), .s_data(s_data0),
    .s_valid(s_valid0), .s_ready(s_ready0), .tdat(tdat0), .busy(busy0),
    .frame_done(frame_done0), .underrun(underrun0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (p < 8) begin
      s_data  = pay_d[p];
      s_valid = pay_v[p];
    end else begin
      s_data  = 10'h000;
      s_valid = 1'b0;
    end
  endtask

  // One clock. The payload pointer advances when the framer took a word.
  task automatic step();
    logic was_ready;
    was_ready = s_ready;
    @(posedge clk);
    #1;
    if (was_ready) p++;
    drive();
  endtask

  initial begin
    n_vec = 0; n_fail = 0; p = 0;
    reset = 1'b1; start = 1'b0;
    start0 = 1'b0; s_data0 = 10'h100; s_valid0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pay_d[i] = 10'(10 + i);
      pay_v[i] = 1'b1;
    end
    drive();
    step();
    step();

    // Reset state
    chk("rst_tdat", tdat, 10'h200);
    chk("rst_busy", {9'd0, busy}, 10'd0);
    chk("rst_done", {9'd0, frame_done}, 10'd0);
    chk("rst_underrun", {9'd0, underrun}, 10'd0);
    chk("rst_ready", {9'd0, s_ready}, 10'd0);
    reset = 1'b0;
    step();

    // Test 1: basic two-line frame
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_first_tdat", tdat, 10'h200);
    busy_cnt = busy ? 1 : 0;
    und_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      step();
      chk($sformatf("t1_tdat[%0d]", i), tdat, exp1[i]);
      if (busy) busy_cnt++;
      if (underrun) und_cnt++;
      if (frame_done) fd_cnt++;
    end
    chk("t1_busy_last", {9'd0, busy}, 10'd0);
    step();
    if (busy) busy_cnt++;
    chk("t1_done", {9'd0, frame_done}, 10'd1);
    chk("t1_tdat_after", tdat, 10'h200);
    chk("t1_busy_cycles", 10'(busy_cnt), 10'd34);
    chk("t1_underruns", 10'(und_cnt), 10'd0);
    chk("t1_early_done", 10'(fd_cnt), 10'd0);
    step();
    chk("t1_done_pulse", {9'd0, frame_done}, 10'd0);

    // Tests 2-4: clipping, underrun, start ignored while busy
    pay_d[0] = 10'h3FF; pay_v[0] = 1'b1;
    pay_d[1] = 10'h000; pay_v[1] = 1'b1;
    pay_d[2] = 10'h155; pay_v[2] = 1'b1;
    pay_d[3] = 10'h123; pay_v[3] = 1'b1;
    pay_d[4] = 10'h050; pay_v[4] = 1'b1;
    pay_d[5] = 10'h051; pay_v[5] = 1'b1;
    pay_d[6] = 10'h0AA; pay_v[6] = 1'b0;
    pay_d[7] = 10'h053; pay_v[7] = 1'b1;
    p = 0;
    drive();
    start = 1'b1;
    step();
    start = 1'b0;
    und_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      step();
      chk($sformatf("t2_tdat[%0d]", i), tdat, exp2[i]);
      chk($sformatf("t3_underrun[%0d]", i), {9'd0, underrun}, (i == 26) ? 10'd1 : 10'd0);
      if (underrun) und_cnt++;
      if (i == 8) start = 1'b1;
      if (i == 9) start = 1'b0;
    end
    chk("t3_underrun_count", 10'(und_cnt), 10'd1);
    step();
    chk("t4_done", {9'd0, frame_done}, 10'd1);
    chk("t4_no_queued_start", {9'd0, busy}, 10'd0);
    chk("t4_idle_tdat", tdat, 10'h200);

    // Test 4: restart straight after frame_done, then test 6: abort mid-payload
    for (int i = 0; i < 8; i++) begin
      pay_d[i] = 10'(10'h040 + i);
      pay_v[i] = 1'b1;
    end
    p = 0;
    drive();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_restart_tdat", tdat, 10'h200);
    chk("t4_restart_busy", {9'd0, busy}, 10'd1);
    chk("t4_restart_done", {9'd0, frame_done}, 10'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t4_sof[%0d]", i), tdat, exp1[i]);
    end
    chk("t6_in_payload", {9'd0, s_ready}, 10'd1);
    reset = 1'b1;
    step();
    chk("t6_rst_tdat", tdat, 10'h200);
    chk("t6_rst_busy", {9'd0, busy}, 10'd0);
    chk("t6_rst_ready", {9'd0, s_ready}, 10'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t6_no_trailer[%0d]", i), tdat, 10'h200);
    end
    chk("t6_still_idle", {9'd0, busy}, 10'd0);

    // Test 5: GAP=0, SOL header directly follows EOL
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t5_first_tdat", tdat0, 10'h200);
    for (int i = 0; i < 32; i++) begin
      step();
      chk($sformatf("t5_tdat[%0d]", i), tdat0, exp0[i]);
    end
    step();
    chk("t5_done", {9'd0, frame_done0}, 10'd1);
    chk("t5_idle_tdat", tdat0, 10'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
